// File: rtl/dac_data_unpack.sv
`default_nettype none
// ============================================================================
//  dac_data_unpack : regroups 3 x 128-bit beats into 2 x 192-bit frames and
//  fans each frame out to 6 per-DAC lanes of 4 expanded samples.
//  Revision: 1.0
// ============================================================================
module dac_data_unpack #(
    parameter int SAMP_W = 16,
    parameter int CNT_W  = 32
) (
    input  logic                     ps_clk,
    input  logic                     ps_rstb,
    input  logic                     flush,
    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    input  logic [127:0]             s_axis_tdata,
    input  logic                     s_axis_tlast,
    output logic [5:0]               m_axis_tvalid,
    input  logic [5:0]               m_axis_tready,
    output logic [6*4*SAMP_W-1:0]    m_axis_tdata,
    output logic [CNT_W-1:0]         frame_cnt,
    output logic                     align_err
);

    localparam logic [1:0]       PH0     = 2'd0;
    localparam logic [1:0]       PH1     = 2'd1;
    localparam logic [1:0]       PH2     = 2'd2;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    logic [1:0]   phase;
    logic [1:0]   phase_nxt;
    logic [127:0] hold;
    logic [191:0] frame;
    logic         frame_valid;
    logic [5:0]   acc;
    logic         s_hs;
    logic         load;
    logic         done;

    assign s_hs = s_axis_tvalid & s_axis_tready;
    assign load = s_hs & (phase != PH0);
    // A frame retires once every lane has either already accepted or accepts now.
    assign done = frame_valid & (&(acc | m_axis_tready));

    always_ff @(posedge ps_clk or negedge ps_rstb) begin
        if (!ps_rstb) begin
            phase <= PH0;
        end else if (flush) begin
            phase <= PH0;
        end else begin
            phase <= phase_nxt;
        end
    end

    always_comb begin
        phase_nxt = phase;
        if (s_hs) begin
            case (phase)
                PH0:     phase_nxt = s_axis_tlast ? PH0 : PH1;
                PH1:     phase_nxt = s_axis_tlast ? PH0 : PH2;
                default: phase_nxt = PH0;
            endcase
        end
    end

    // Frames only load while no frame is pending, so the lane data never moves under a valid.
    always_comb begin
        s_axis_tready = (phase == PH0) | ~frame_valid;
        m_axis_tvalid = {6{frame_valid}} & ~acc;
    end

    always_ff @(posedge ps_clk or negedge ps_rstb) begin
        if (!ps_rstb) begin
            hold        <= '0;
            frame       <= '0;
            frame_valid <= 1'b0;
            acc         <= '0;
        end else if (flush) begin
            hold        <= '0;
            frame       <= '0;
            frame_valid <= 1'b0;
            acc         <= '0;
        end else begin
            if (s_hs && phase == PH0) begin
                hold <= s_axis_tdata;
            end else if (s_hs && phase == PH1) begin
                hold[63:0] <= s_axis_tdata[127:64];
                frame      <= {s_axis_tdata[63:0], hold};
            end else if (s_hs) begin
                frame      <= {s_axis_tdata, hold[63:0]};
            end

            if (load) begin
                frame_valid <= 1'b1;
            end else if (done) begin
                frame_valid <= 1'b0;
            end

            if (done) begin
                acc <= '0;
            end else if (frame_valid) begin
                acc <= acc | m_axis_tready;
            end
        end
    end

    always_ff @(posedge ps_clk or negedge ps_rstb) begin
        if (!ps_rstb) begin
            frame_cnt <= '0;
            align_err <= 1'b0;
        end else if (flush) begin
            align_err <= 1'b0;
        end else begin
            if (done) begin
                frame_cnt <= frame_cnt + CNT_ONE;
            end
            if (s_hs && s_axis_tlast && phase != PH2) begin
                align_err <= 1'b1;
            end
        end
    end

    for (genvar ch = 0; ch < 6; ch++) begin : g_lane
        for (genvar s = 0; s < 4; s++) begin : g_samp
            if (SAMP_W > 8) begin : g_pad
                assign m_axis_tdata[ch*4*SAMP_W + s*SAMP_W +: SAMP_W] =
                    {frame[(s*6+ch)*8 +: 8], {(SAMP_W-8){1'b0}}};
            end else begin : g_nopad
                assign m_axis_tdata[ch*4*SAMP_W + s*SAMP_W +: SAMP_W] = frame[(s*6+ch)*8 +: 8];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dac_data_unpack.sv
`default_nettype none
// ============================================================================
//  tb_dac_data_unpack : scoreboard bench for dac_data_unpack.
//  Revision: 1.0
// ============================================================================
module tb_dac_data_unpack;

    localparam int SAMP_W = 16;
    localparam int LW     = 4*SAMP_W;

    logic              ps_clk = 1'b0;
    logic              ps_rstb = 1'b0;
    logic              flush = 1'b0;
    logic              s_axis_tvalid = 1'b0;
    logic              s_axis_tlast = 1'b0;
    logic [127:0]      s_axis_tdata = '0;
    logic [5:0]        m_axis_tready = 6'h3f;
    logic              s_axis_tready;
    logic [5:0]        m_axis_tvalid;
    logic [6*LW-1:0]   m_axis_tdata;
    logic [31:0]       frame_cnt;
    logic              align_err;
    logic              s_axis_tready4;
    logic [5:0]        m_axis_tvalid4;
    logic [6*LW-1:0]   m_axis_tdata4;
    logic [3:0]        cnt4;
    logic              align_err4;

    dac_data_unpack #(.SAMP_W(SAMP_W), .CNT_W(32)) dut (
        .ps_clk(ps_clk), .ps_rstb(ps_rstb), .flush(flush),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tdata(m_axis_tdata), .frame_cnt(frame_cnt), .align_err(align_err)
    );

    dac_data_unpack #(.SAMP_W(SAMP_W), .CNT_W(4)) dut4 (
        .ps_clk(ps_clk), .ps_rstb(ps_rstb), .flush(flush),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready4),
        .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
        .m_axis_tvalid(m_axis_tvalid4), .m_axis_tready(m_axis_tready),
        .m_axis_tdata(m_axis_tdata4), .frame_cnt(cnt4), .align_err(align_err4)
    );

    always #5 ps_clk = ~ps_clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [LW-1:0] exp_q [6][$];
    int            hs_cnt [6];
    logic [LW-1:0] lane_log [6][4];
    int            m_phase = 0;
    logic [127:0]  m_hold = '0;

    always @(negedge ps_clk) begin
        logic [LW-1:0] d;
        for (int ch = 0; ch < 6; ch++) begin
            if (ps_rstb && m_axis_tvalid[ch] && m_axis_tready[ch]) begin
                d = m_axis_tdata[ch*LW +: LW];
                if (hs_cnt[ch] < 4) lane_log[ch][hs_cnt[ch]] = d;
                hs_cnt[ch]++;
                if (exp_q[ch].size() == 0)
                    check($sformatf("lane%0d_unexpected_beat", ch), 1, 0);
                else
                    check($sformatf("lane%0d_data", ch), d, exp_q[ch].pop_front());
            end
        end
    end

    task automatic push_frame(input logic [191:0] f);
        logic [LW-1:0] l;
        for (int ch = 0; ch < 6; ch++) begin
            for (int s = 0; s < 4; s++)
                l[s*SAMP_W +: SAMP_W] = {f[(s*6+ch)*8 +: 8], {(SAMP_W-8){1'b0}}};
            exp_q[ch].push_back(l);
        end
    endtask

    task automatic clear_model();
        for (int ch = 0; ch < 6; ch++) exp_q[ch].delete();
        m_phase = 0;
        m_hold  = '0;
    endtask

    task automatic clear_hs();
        for (int ch = 0; ch < 6; ch++) hs_cnt[ch] = 0;
    endtask

    // Called and returns at posedge+1; n = cycles spent until the beat was taken.
    task automatic send_beat(input logic [127:0] d, input logic last, output int n);
        logic got;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tlast  = last;
        n = 0;
        do begin
            @(negedge ps_clk);
            got = s_axis_tready;
            @(posedge ps_clk);
            #1;
            n++;
        end while (!got && n < 200);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        if (!got) begin
            check("s_handshake_timeout", 0, 1);
        end else begin
            case (m_phase)
                0: begin m_hold = d; m_phase = last ? 0 : 1; end
                1: begin
                    push_frame({d[63:0], m_hold});
                    m_hold[63:0] = d[127:64];
                    m_phase = last ? 0 : 2;
                end
                default: begin push_frame({d, m_hold[63:0]}); m_phase = 0; end
            endcase
        end
    endtask

    function automatic logic [127:0] seq_beat(input int base);
        logic [127:0] b;
        for (int i = 0; i < 16; i++) b[i*8 +: 8] = 8'(base + i);
        return b;
    endfunction

    task automatic send_seq(input int base, input int beats);
        int n;
        for (int k = 0; k < beats; k++) send_beat(seq_beat(base + 16*k), 1'b0, n);
    endtask

    function automatic bit queues_empty();
        for (int ch = 0; ch < 6; ch++) if (exp_q[ch].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic wait_drain();
        int n = 0;
        while (!(queues_empty() && m_axis_tvalid == 6'h00) && n < 200) begin
            @(posedge ps_clk);
            #1;
            n++;
        end
        check("drain_timeout", n < 200, 1);
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        @(posedge ps_clk);
        #1;
        flush = 1'b0;
    endtask

    initial begin
        int n;
        logic [31:0]   base;
        logic [LW-1:0] ref3;

        clear_hs();
        repeat (3) @(posedge ps_clk);
        #1;
        check("rst_s_tready", s_axis_tready, 1);
        check("rst_m_tvalid", m_axis_tvalid, 0);
        check("rst_m_tdata",  m_axis_tdata, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_align_err", align_err, 0);
        ps_rstb = 1'b1;
        @(posedge ps_clk);
        #1;

        // Sequential bytes 0..47, all lanes ready.
        send_seq(0, 3);
        wait_drain();
        check("t1_lane0_f0", lane_log[0][0], {16'h1200, 16'h0C00, 16'h0600, 16'h0000});
        check("t1_lane5_f0", lane_log[5][0], {16'h1700, 16'h1100, 16'h0B00, 16'h0500});
        check("t1_lane0_f1", lane_log[0][1], {16'h2A00, 16'h2400, 16'h1E00, 16'h1800});
        check("t1_frame_cnt", frame_cnt, 2);

        // Lane 3 stalled for 10 cycles on frame 0.
        clear_hs();
        m_axis_tready = 6'b110111;
        send_beat(seq_beat(8'h40), 1'b0, n);
        send_beat(seq_beat(8'h50), 1'b0, n);
        @(negedge ps_clk);
        ref3 = m_axis_tdata[3*LW +: LW];
        for (int i = 0; i < 10; i++) begin
            check("t2_lane3_valid", m_axis_tvalid[3], 1);
            check("t2_lane3_stable", m_axis_tdata[3*LW +: LW], ref3);
            check("t2_s_tready_low", s_axis_tready, 0);
            @(negedge ps_clk);
        end
        for (int ch = 0; ch < 6; ch++)
            check($sformatf("t2_hs_lane%0d", ch), hs_cnt[ch], (ch == 3) ? 0 : 1);
        @(posedge ps_clk);
        #1;
        m_axis_tready = 6'h3f;
        send_beat(seq_beat(8'h60), 1'b0, n);
        check("t2_beat2_cycles", n, 2);
        @(negedge ps_clk);
        check("t2_frame1_valid", m_axis_tvalid, 6'h3f);
        @(posedge ps_clk);
        #1;
        wait_drain();
        for (int ch = 0; ch < 6; ch++)
            check($sformatf("t2_total_hs_lane%0d", ch), hs_cnt[ch], 2);

        // Continuous random stream.
        base = frame_cnt;
        for (int k = 0; k < 300; k++)
            send_beat({$urandom, $urandom, $urandom, $urandom}, 1'b0, n);
        wait_drain();
        check("t3_frame_cnt", frame_cnt - base, 200);

        // tlast on phase 1, then phase 0, then flush behaviour.
        base = frame_cnt;
        send_beat(seq_beat(8'h80), 1'b0, n);
        send_beat(seq_beat(8'h90), 1'b1, n);
        wait_drain();
        check("t4_one_frame", frame_cnt, base + 1);
        check("t4_align_err", align_err, 1);
        send_seq(8'hA0, 3);
        wait_drain();
        check("t4_realigned_cnt", frame_cnt, base + 3);
        check("t4_err_sticky", align_err, 1);
        pulse_flush();
        check("t4_flush_err", align_err, 0);
        check("t4_flush_cnt", frame_cnt, base + 3);
        send_beat(seq_beat(8'h10), 1'b1, n);
        check("t4_ph0_err", align_err, 1);
        send_seq(8'h20, 3);
        wait_drain();
        check("t4_ph0_cnt", frame_cnt, base + 5);
        m_axis_tready = 6'h00;
        send_seq(8'h30, 2);
        pulse_flush();
        clear_model();
        m_axis_tready = 6'h3f;
        check("t4_flush_tvalid", m_axis_tvalid, 0);
        check("t4_flush_tready", s_axis_tready, 1);
        check("t4_flush_tdata", m_axis_tdata, 0);
        check("t4_flush_drop_cnt", frame_cnt, base + 5);
        send_seq(8'h70, 3);
        wait_drain();
        check("t4_post_flush_cnt", frame_cnt, base + 7);

        // Asynchronous reset after two lanes accepted.
        clear_hs();
        m_axis_tready = 6'b000011;
        send_seq(8'hC0, 2);
        @(negedge ps_clk);
        @(posedge ps_clk);
        #2;
        ps_rstb = 1'b0;
        #1;
        check("t5_hs_before_rst", {hs_cnt[0] == 1, hs_cnt[1] == 1, hs_cnt[2] == 0}, 3'b111);
        check("t5_async_tvalid", m_axis_tvalid, 0);
        check("t5_async_cnt", frame_cnt, 0);
        check("t5_async_tready", s_axis_tready, 1);
        clear_model();
        clear_hs();
        @(negedge ps_clk);
        ps_rstb = 1'b1;
        m_axis_tready = 6'h3f;
        @(posedge ps_clk);
        #1;
        send_seq(0, 3);
        wait_drain();
        check("t5_lane0_f0", lane_log[0][0], {16'h1200, 16'h0C00, 16'h0600, 16'h0000});
        check("t5_lane0_f1", lane_log[0][1], {16'h2A00, 16'h2400, 16'h1E00, 16'h1800});
        check("t5_frame_cnt", frame_cnt, 2);

        // 4-bit counter wraps on the 16th frame since reset.
        send_seq(8'h05, 18);
        send_seq(8'h33, 2);
        wait_drain();
        check("t6_cnt4_15", cnt4, 15);
        send_seq(8'h55, 1);
        wait_drain();
        check("t6_cnt4_wrap", cnt4, 0);
        check("t6_cnt32_16", frame_cnt, 16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
